apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 30 +++
 rtl/apb_master_bridge.sv | 119 +++++++++++
 tb/tb_apb_master_bridge.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the APB master bridge, its requester and the UART APB slave.
// The master modport is the bridge's view; slave is the environment's view.
interface apb_master_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pwakeup;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pwakeup,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pwakeup,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-request APB master bridge: waits for slave wakeup, runs one APB transfer,
// and returns a one-cycle response strobe with a timeout error flag.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned WAKE_WAIT = 16
) (
  input logic                 pclk,
  input logic                 rst,
  apb_master_bridge_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAKE   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // One counter serves both WAKE and ACCESS, so it is sized for the longer wait.
  localparam int unsigned CNT_MAX = (TIMEOUT > WAKE_WAIT) ? TIMEOUT : WAKE_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             apb_active;

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = bus.pwakeup ? S_SETUP : S_WAKE;
        end
      end
      S_WAKE: begin
        if (bus.pwakeup) begin
          state_d = S_SETUP;
        end else if (cnt_q >= WAKE_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 8'h00;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        // pready is tested before the timeout so a last-cycle ready still completes cleanly.
        if (bus.pready) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? 8'h00 : bus.prdata;
        end else if (cnt_q >= ACC_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 8'h00;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign apb_active = (state_q == S_SETUP) || (state_q == S_ACCESS);

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.psel      = apb_active;
  assign bus.penable   = (state_q == S_ACCESS);
  assign bus.pwrite    = apb_active && write_q;
  assign bus.paddr     = apb_active ? addr_q : 32'h0;
  assign bus.pwdata    = apb_active ? wdata_q : 8'h00;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with TIMEOUT=8, WAKE_WAIT=16.
// Inputs change and outputs are sampled on the falling edge of pclk.
module tb_apb_master_bridge;
  logic pclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge_if bus();

  apb_master_bridge #(.TIMEOUT(8), .WAKE_WAIT(16)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Observations of the most recent transaction, filled by transact().
  int         r_setup, r_access, r_lat;
  logic       r_err, r_unstable, r_timeout, r_rsp_after, r_ready_after;
  logic [7:0] r_rdata, r_rdata_after;

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 8'h00;
    bus.prdata    = 8'h00;
    bus.pready    = 1'b0;
    bus.pwakeup   = 1'b0;
  endtask

  // wake_cycles: WAKE cycles with pwakeup low before it rises (0 = high at accept, -1 = never).
  // ready_on: ACCESS cycle (1-based) on which pready is high (0 = never).
  // r_lat counts cycles from the acceptance cycle to the rsp_valid cycle.
  task automatic transact(input logic w, input logic [31:0] a, input logic [7:0] d,
                          input int wake_cycles, input int ready_on, input logic [7:0] rd);
    int  k;
    bit  done;
    r_setup = 0; r_access = 0; r_lat = 0; r_err = 1'bx; r_rdata = 8'hxx;
    r_unstable = 1'b0; r_timeout = 1'b0; r_rsp_after = 1'bx; r_ready_after = 1'bx;
    r_rdata_after = 8'hxx;
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.prdata    = rd;
    bus.pready    = 1'b0;
    bus.pwakeup   = (wake_cycles == 0);
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge pclk);
      k++;
    end
    if (!bus.req_ready) begin
      r_timeout = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    k = 0;
    done = 0;
    while (!done && k < 100) begin
      @(negedge pclk);
      k++;
      bus.req_valid = 1'b0;
      bus.pwakeup   = (wake_cycles >= 0) && (k > wake_cycles);
      bus.pready    = 1'b0;
      if (bus.psel && !bus.penable) r_setup++;
      if (bus.psel && bus.penable) begin
        r_access++;
        bus.pready = (r_access == ready_on);
      end
      if (bus.psel && (bus.paddr !== a || bus.pwrite !== w || bus.pwdata !== d)) r_unstable = 1'b1;
      if (bus.rsp_valid) begin
        r_lat   = k;
        r_err   = bus.rsp_err;
        r_rdata = bus.rsp_rdata;
        done    = 1;
      end
    end
    if (!done) begin
      r_timeout = 1'b1;
      return;
    end
    @(negedge pclk);
    r_rsp_after   = bus.rsp_valid;
    r_rdata_after = bus.rsp_rdata;
    r_ready_after = bus.req_ready;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000 (psel,penable,pwrite,rsp_valid,rsp_err,req_ready)",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h expected all zero",
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge pclk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    transact(1'b1, 32'h0000_0010, 8'hA5, 0, 3, 8'hEE);
    checks++;
    if (r_timeout !== 1'b0) begin errors++; $display("FAIL write_hang: transaction did not complete"); end
    checks++;
    if (r_setup !== 1 || r_access !== 3) begin
      errors++;
      $display("FAIL write_phases: setup=%0d access=%0d expected 1 and 3", r_setup, r_access);
    end
    checks++;
    if (r_unstable !== 1'b0) begin errors++; $display("FAIL write_stable: paddr/pwrite/pwdata not held at 0x10/1/0xA5"); end
    checks++;
    if (r_lat !== 5 || r_err !== 1'b0 || r_rdata !== 8'h00) begin
      errors++;
      $display("FAIL write_rsp: lat=%0d err=%b rdata=%h expected 5 0 00", r_lat, r_err, r_rdata);
    end
    checks++;
    if (r_rsp_after !== 1'b0) begin errors++; $display("FAIL write_rsp_width: rsp_valid=%b after strobe expected 0", r_rsp_after); end
  endtask

  task automatic test_read();
    transact(1'b0, 32'h0000_0024, 8'h00, 0, 1, 8'h3C);
    checks++;
    if (r_timeout !== 1'b0 || r_access !== 1) begin
      errors++;
      $display("FAIL read_phases: timeout=%b access=%0d expected 0 and 1", r_timeout, r_access);
    end
    checks++;
    if (r_lat !== 3 || r_err !== 1'b0 || r_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL read_rsp: lat=%0d err=%b rdata=%h expected 3 0 3c", r_lat, r_err, r_rdata);
    end
    checks++;
    if (r_rsp_after !== 1'b0 || r_ready_after !== 1'b1 || r_rdata_after !== 8'h3C) begin
      errors++;
      $display("FAIL read_after: rsp_valid=%b req_ready=%b rdata=%h expected 0 1 3c",
               r_rsp_after, r_ready_after, r_rdata_after);
    end
  endtask

  task automatic test_timeout();
    transact(1'b0, 32'h0000_0030, 8'h00, 0, 0, 8'h77);
    checks++;
    if (r_access !== 8 || r_lat !== 10) begin
      errors++;
      $display("FAIL timeout_len: access=%0d lat=%0d expected 8 and 10", r_access, r_lat);
    end
    checks++;
    if (r_err !== 1'b1 || r_rdata !== 8'h00) begin
      errors++;
      $display("FAIL timeout_rsp: err=%b rdata=%h expected 1 00", r_err, r_rdata);
    end
    transact(1'b0, 32'h0000_0034, 8'h00, 0, 8, 8'h5A);
    checks++;
    if (r_access !== 8 || r_err !== 1'b0 || r_rdata !== 8'h5A || r_lat !== 10) begin
      errors++;
      $display("FAIL timeout_edge: access=%0d err=%b rdata=%h lat=%0d expected 8 0 5a 10",
               r_access, r_err, r_rdata, r_lat);
    end
  endtask

  task automatic test_wake();
    transact(1'b1, 32'h0000_0040, 8'h11, -1, 1, 8'h00);
    checks++;
    if (r_setup !== 0 || r_access !== 0) begin
      errors++;
      $display("FAIL wake_timeout_psel: setup=%0d access=%0d expected 0 0", r_setup, r_access);
    end
    checks++;
    if (r_lat !== 17 || r_err !== 1'b1 || r_rdata !== 8'h00) begin
      errors++;
      $display("FAIL wake_timeout_rsp: lat=%0d err=%b rdata=%h expected 17 1 00", r_lat, r_err, r_rdata);
    end
    transact(1'b0, 32'h0000_0044, 8'h00, 15, 1, 8'hC3);
    checks++;
    if (r_lat !== 19 || r_err !== 1'b0 || r_rdata !== 8'hC3 || r_setup !== 1) begin
      errors++;
      $display("FAIL wake_late: lat=%0d err=%b rdata=%h setup=%0d expected 19 0 c3 1",
               r_lat, r_err, r_rdata, r_setup);
    end
  endtask

  task automatic test_reset_access();
    int rsp = 0;
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0050;
    bus.req_wdata = 8'h99;
    bus.pwakeup   = 1'b1;
    bus.pready    = 1'b0;
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(negedge pclk);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_access_entry: psel,penable=%b expected 11", {bus.psel, bus.penable});
    end
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 6'b0 ||
        {bus.paddr, bus.pwdata, bus.rsp_rdata} !== 48'h0) begin
      errors++;
      $display("FAIL rst_access_outputs: ctrl=%b paddr=%h pwdata=%h rdata=%h expected all zero",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready},
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) rsp++;
    end
    checks++;
    if (rsp !== 0) begin errors++; $display("FAIL rst_access_no_rsp: got %0d strobes expected 0", rsp); end
    transact(1'b0, 32'h0000_0058, 8'h00, 0, 2, 8'h81);
    checks++;
    if (r_lat !== 4 || r_err !== 1'b0 || r_rdata !== 8'h81) begin
      errors++;
      $display("FAIL rst_access_recover: lat=%0d err=%b rdata=%h expected 4 0 81", r_lat, r_err, r_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsp = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0060;
    bus.prdata    = 8'h42;
    bus.pwakeup   = 1'b1;
    bus.pready    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge pclk);
      if (bus.req_ready) acc++;
      if (bus.rsp_valid) rsp++;
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) rsp++;
    end
    checks++;
    if (acc !== 5) begin errors++; $display("FAIL b2b_accepts: got %0d expected 5", acc); end
    checks++;
    if (rsp !== 5) begin errors++; $display("FAIL b2b_responses: got %0d expected 5", rsp); end
    checks++;
    if (bus.rsp_rdata !== 8'h42) begin errors++; $display("FAIL b2b_rdata: got %h expected 42", bus.rsp_rdata); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_wake();
    test_reset_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
